hazard_stall_unit: RTL and testbench

//  Companion to ForwardUnit in the 5-stage MIPS pipeline. It detects hazards that forwarding cannot

---
 rtl/hazard_stall_unit.sv | 114 +++++++++++
 tb/tb_hazard_stall_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit
// Brief    : Load-use / branch-operand / mult-div hazard detection with
//            PC, IF/ID and ID/EX stall-flush control and a stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
   parameter int MULDIV_CYCLES = 4,
   parameter int STALL_CNT_W   = 32
) (
   input  logic                   iCLK,
   input  logic                   iRST,
   input  logic [4:0]             iID_NumRs,
   input  logic [4:0]             iID_NumRt,
   input  logic                   iID_UsesRt,
   input  logic                   iID_Branch,
   input  logic                   iID_MulDiv,
   input  logic                   iID_ReadHiLo,
   input  logic                   iBranchTaken,
   input  logic [4:0]             iEX_NumRd,
   input  logic                   iEX_RegWrite,
   input  logic                   iEX_MemRead,
   input  logic [4:0]             iMEM_NumRd,
   input  logic                   iMEM_MemRead,
   output logic                   oPCWrite,
   output logic                   oIFID_Write,
   output logic                   oIFID_Flush,
   output logic                   oIDEX_Flush,
   output logic                   oMulDivBusy,
   output logic [STALL_CNT_W-1:0] oStallCycles
);

   localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);
   localparam logic [CNT_W-1:0] C_MD_LOAD = CNT_W'(MULDIV_CYCLES);
   localparam logic [CNT_W-1:0] C_MD_LAST = CNT_W'(1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } md_state_t;

   md_state_t              r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [STALL_CNT_W-1:0] r_stall_cycles;

   logic w_ex_match;
   logic w_mem_match;
   logic w_load_use;
   logic w_br_ex;
   logic w_br_mem_load;
   logic w_md_hazard;
   logic w_stall;
   logic w_stall_out;

   // Register $0 is hard-wired zero, so it never creates a dependency.
   function automatic logic f_match(input logic [4:0] rd, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic uses_rt);
      return (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
   endfunction

   assign w_ex_match    = f_match(iEX_NumRd,  iID_NumRs, iID_NumRt, iID_UsesRt);
   assign w_mem_match   = f_match(iMEM_NumRd, iID_NumRs, iID_NumRt, iID_UsesRt);
   assign w_load_use    = iEX_MemRead && w_ex_match;
   assign w_br_ex       = iID_Branch && iEX_RegWrite && w_ex_match;
   assign w_br_mem_load = iID_Branch && iMEM_MemRead && w_mem_match;
   assign w_md_hazard   = (r_cnt != '0) && (iID_ReadHiLo || iID_MulDiv);
   assign w_stall       = w_load_use || w_br_ex || w_br_mem_load || w_md_hazard;
   assign w_stall_out   = w_stall && !iRST;

   // A stalled branch has invalid operands, so its redirect is ignored.
   assign oPCWrite     = !w_stall_out;
   assign oIFID_Write  = !w_stall_out;
   assign oIDEX_Flush  = w_stall_out;
   assign oIFID_Flush  = !iRST && !w_stall && iBranchTaken;
   assign oMulDivBusy  = (r_state == S_BUSY) && !iRST;
   assign oStallCycles = r_stall_cycles;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (iID_MulDiv && !w_stall) begin
                  r_cnt   <= C_MD_LOAD;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt - C_MD_LAST;
               if (r_cnt == C_MD_LAST) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_stall_cycles <= '0;
      end else if (w_stall && (r_stall_cycles != '1)) begin
         r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_unit
// Brief    : Directed table-driven and sequence checks for hazard_stall_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
   logic       uses_rt, branch, muldiv, readhilo, taken;
   logic       ex_rw, ex_mr, mem_mr;

   logic        pcw, ifidw, ifidf, idexf, busy;
   logic [31:0] stalls;
   logic        pcw_s, ifidw_s, ifidf_s, idexf_s, busy_s;
   logic [3:0]  stalls_s;

   hazard_stall_unit #(.MULDIV_CYCLES(4), .STALL_CNT_W(32)) dut (
      .iCLK(clk), .iRST(rst),
      .iID_NumRs(id_rs), .iID_NumRt(id_rt), .iID_UsesRt(uses_rt),
      .iID_Branch(branch), .iID_MulDiv(muldiv), .iID_ReadHiLo(readhilo),
      .iBranchTaken(taken),
      .iEX_NumRd(ex_rd), .iEX_RegWrite(ex_rw), .iEX_MemRead(ex_mr),
      .iMEM_NumRd(mem_rd), .iMEM_MemRead(mem_mr),
      .oPCWrite(pcw), .oIFID_Write(ifidw), .oIFID_Flush(ifidf),
      .oIDEX_Flush(idexf), .oMulDivBusy(busy), .oStallCycles(stalls)
   );

   hazard_stall_unit #(.MULDIV_CYCLES(4), .STALL_CNT_W(4)) dut_s (
      .iCLK(clk), .iRST(rst),
      .iID_NumRs(id_rs), .iID_NumRt(id_rt), .iID_UsesRt(uses_rt),
      .iID_Branch(branch), .iID_MulDiv(muldiv), .iID_ReadHiLo(readhilo),
      .iBranchTaken(taken),
      .iEX_NumRd(ex_rd), .iEX_RegWrite(ex_rw), .iEX_MemRead(ex_mr),
      .iMEM_NumRd(mem_rd), .iMEM_MemRead(mem_mr),
      .oPCWrite(pcw_s), .oIFID_Write(ifidw_s), .oIFID_Flush(ifidf_s),
      .oIDEX_Flush(idexf_s), .oMulDivBusy(busy_s), .oStallCycles(stalls_s)
   );

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       branch;
      logic       readhilo;
      logic       taken;
      logic [4:0] ex_rd;
      logic       ex_rw;
      logic       ex_mr;
      logic [4:0] mem_rd;
      logic       mem_mr;
      logic       exp_stall;
      logic       exp_iflush;
   } vec_t;

   vec_t vec [12];
   int   n_pass = 0;
   int   n_total = 0;
   int   exp_stalls = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic idle_in();
      id_rs = 0; id_rt = 0; uses_rt = 0; branch = 0; muldiv = 0; readhilo = 0;
      taken = 0; ex_rd = 0; ex_rw = 0; ex_mr = 0; mem_rd = 0; mem_mr = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks the four pipeline controls for a given stall / branch-flush expectation.
   task automatic chk_ctl(input string nm, input logic s, input logic f);
      chk({nm, ".pcw"},   {31'd0, pcw},   {31'd0, !s});
      chk({nm, ".ifidw"}, {31'd0, ifidw}, {31'd0, !s});
      chk({nm, ".idexf"}, {31'd0, idexf}, {31'd0, s});
      chk({nm, ".ifidf"}, {31'd0, ifidf}, {31'd0, f});
   endtask

   initial begin
      //        rs  rt ur br hl tk exrd rw mr memrd mm  st fl
      vec[0]  = '{0,  0, 0, 0, 0, 0, 0,  0, 0, 0,  0,  0, 0};
      vec[1]  = '{8,  0, 0, 0, 0, 0, 8,  1, 1, 0,  0,  1, 0};
      vec[2]  = '{0,  0, 0, 0, 0, 0, 0,  1, 1, 0,  0,  0, 0};
      vec[3]  = '{1,  9, 0, 0, 0, 0, 9,  1, 1, 0,  0,  0, 0};
      vec[4]  = '{1,  9, 1, 0, 0, 0, 9,  1, 1, 0,  0,  1, 0};
      vec[5]  = '{9,  0, 0, 1, 0, 1, 9,  1, 0, 0,  0,  1, 0};
      vec[6]  = '{3,  4, 1, 1, 0, 1, 9,  1, 0, 0,  0,  0, 1};
      vec[7]  = '{9,  0, 0, 0, 0, 0, 9,  1, 0, 0,  0,  0, 0};
      vec[8]  = '{5,  0, 0, 1, 0, 0, 0,  0, 0, 5,  1,  1, 0};
      vec[9]  = '{5,  0, 0, 0, 0, 0, 0,  0, 0, 5,  1,  0, 0};
      vec[10] = '{2,  7, 1, 1, 0, 1, 0,  0, 0, 7,  1,  1, 0};
      vec[11] = '{0,  0, 0, 0, 1, 0, 0,  0, 0, 0,  0,  0, 0};

      idle_in();
      rst = 1;
      step();
      step();
      chk("reset.stalls", stalls, 0);
      chk("reset.busy", {31'd0, busy}, 0);
      chk_ctl("reset", 0, 0);
      rst = 0;

      for (int i = 0; i < 12; i++) begin
         id_rs = vec[i].rs; id_rt = vec[i].rt; uses_rt = vec[i].uses_rt;
         branch = vec[i].branch; readhilo = vec[i].readhilo; taken = vec[i].taken;
         ex_rd = vec[i].ex_rd; ex_rw = vec[i].ex_rw; ex_mr = vec[i].ex_mr;
         mem_rd = vec[i].mem_rd; mem_mr = vec[i].mem_mr; muldiv = 0;
         #3;
         chk_ctl($sformatf("vec%0d", i), vec[i].exp_stall, vec[i].exp_iflush);
         if (vec[i].exp_stall) exp_stalls++;
         step();
      end
      chk("table.stalls", stalls, exp_stalls);

      // Load-use: one bubble, then the load has moved to MEM and ID proceeds.
      idle_in(); ex_rd = 8; ex_rw = 1; ex_mr = 1; id_rs = 8;
      #3; chk_ctl("lu.c1", 1, 0);
      step(); exp_stalls++;
      idle_in(); mem_rd = 8; mem_mr = 1; id_rs = 8;
      #3; chk_ctl("lu.c2", 0, 0);
      chk("lu.stalls", stalls, exp_stalls);
      step();

      // Branch on a load in EX stalls two cycles.
      idle_in(); ex_rd = 9; ex_rw = 1; ex_mr = 1; id_rs = 9; branch = 1;
      #3; chk_ctl("br.c1", 1, 0);
      step(); exp_stalls++;
      idle_in(); mem_rd = 9; mem_mr = 1; id_rs = 9; branch = 1;
      #3; chk_ctl("br.c2", 1, 0);
      step(); exp_stalls++;
      idle_in(); id_rs = 9; branch = 1; taken = 1;
      #3; chk_ctl("br.c3", 0, 1);
      chk("br.stalls", stalls, exp_stalls);
      step();

      // mult accepted at t, mfhi waits t+1..t+4, proceeds at t+5.
      idle_in(); muldiv = 1;
      #3; chk_ctl("md.t0", 0, 0);
      chk("md.t0.busy", {31'd0, busy}, 0);
      step();
      idle_in(); readhilo = 1;
      for (int k = 1; k <= 4; k++) begin
         #3;
         chk_ctl($sformatf("md.t%0d", k), 1, 0);
         chk($sformatf("md.t%0d.busy", k), {31'd0, busy}, 1);
         step(); exp_stalls++;
      end
      #3;
      chk_ctl("md.t5", 0, 0);
      chk("md.t5.busy", {31'd0, busy}, 0);
      chk("md.stalls", stalls, exp_stalls);
      step();

      // Reset in the middle of a mult/div: cnt 4 -> 3 -> 2, then reset.
      idle_in(); muldiv = 1;
      step();
      idle_in();
      step();
      step();
      chk("rst.pre.busy", {31'd0, busy}, 1);
      ex_rd = 8; ex_mr = 1; ex_rw = 1; id_rs = 8; branch = 1; taken = 1; rst = 1;
      #3; chk_ctl("rst.forced", 0, 0);
      chk("rst.forced.busy", {31'd0, busy}, 0);
      step();
      chk("rst.stalls", stalls, 0);
      rst = 0; idle_in();
      #3; chk("rst.post.busy", {31'd0, busy}, 0);
      chk("rst.post.stalls", stalls, 0);

      // Saturation: a 4-bit counter holds at 15 while the 32-bit one keeps counting.
      ex_rd = 8; ex_rw = 1; ex_mr = 1; id_rs = 8;
      for (int k = 0; k < 20; k++) step();
      chk("sat.s", {28'd0, stalls_s}, 15);
      chk("sat.main", stalls, 20);
      step();
      chk("sat.s.hold", {28'd0, stalls_s}, 15);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
